prnd_pwm_dither_mc: RTL and testbench
=====================================

// Module: prnd_pwm_dither_mc
// PURPOSE
//  Multi-channel pseudorandom PWM dither generator, single clock domain.
//  Each frame is divisor clocks long. Per channel, it emits a pulse of width_i clocks.
//  The pulse starts at a per-frame pseudorandom offset and wraps modulo divisor.
//  Successor to the two-clock dither cell: internal per-channel LFSRs, on-chip frame counter,
//  N channels, and a fixed-offset (non-dithered) mode. Drives fractional divider/DCO trim bits.
// PARAMETERS
//  NUM_PRND_BITS  5       W: width of each channel's width and LFSR fields; divisor is W+1 bits
//  NUM_CHANNELS   4       N: number of independent dither outputs
//  POLY           5'h14   Galois LFSR feedback mask (right-shift form; default x^5+x^3+1, period 31)
//  SEED           5'h01   LFSR seed of channel 0; channel i is seeded with SEED+i (mod 2^W), and a value of 0 is replaced by 1
// PORTS
//  clock       in   1      Single clock, rising edge
//  reset       in   1      Synchronous, active-high
//  enable      in   1      1 = run frames; 0 = idle, outputs low
//  ditherEn    in   1      1 = pseudorandom offsets; 0 = offset 0 (plain PWM); sampled at frame load
//  divisor     in   W+1    Frame length in clocks; sampled at frame load
//  width       in   N*W    Channel i pulse width is width[i*W +: W]; sampled at frame load
//  ditherBits  out  N      Registered dither outputs
//  frameStart  out  1      Registered; high during cycle 0 of every frame
// BEHAVIOUR
//  Reset (next edge): state IDLE; cnt=0; lfsr_i=seed_i; ditherBits=0; frameStart=0.
//  States:
//   IDLE: ditherBits=0, frameStart=0, cnt=0, LFSRs hold. When enable=1, frame load -> RUN.
//   RUN: cnt increments each clock. When cnt==divL-1, frame load and cnt wraps to 0.
//   RUN with enable=0: next edge -> IDLE, with outputs and cnt cleared. LFSRs hold, so the sequence resumes on re-entry.
//  Frame load (one edge):
//   divL = clamp(divisor, 1, 2^W): 0 is treated as 1; values above 2^W are treated as 2^W.
//   wL_i = width_i.
//   off_i = ditherEn ? (lfsr_i * divL) >> W : 0. This uses the pre-advance lfsr_i and the new divL, so 0 <= off_i < divL.
//   Every lfsr_i advances once, regardless of ditherEn: lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
//  Output timing: ditherBits and frameStart are flops aligned with cnt. The first RUN cycle after a load has cnt=0 and frameStart=1.
//  Output value in the cycle with cnt=k: ditherBits[i]=1 iff d < wL_i,
//   where d = (k >= off_i) ? k-off_i : k+divL-off_i.
//  Width boundaries:
//   wL_i=0 gives a constant 0.
//   wL_i >= divL gives a constant 1 for the whole frame.
//   A window that passes divL-1 wraps to cycle 0 of the same frame.
//  divL=1: every cycle is a frame; frameStart stays high; ditherBits[i] = (wL_i != 0).
//  Changes to divisor, width or ditherEn mid-frame are ignored until the next load. No partial frames occur.
//  Reset mid-frame overrides enable and all other inputs.
//  Arithmetic: product is 2W+1 bits; d and cnt are W+1 bits; no overflow for divL <= 2^W.
//  Latency: the first frameStart appears 1 edge after enable rises in IDLE. Outputs drop 1 edge after enable falls.
// TESTING (W=5, N=2, POLY=5'h14, SEED=1; ch0 LFSR sequence 1,20,10,5,...)
//  1 Reset held 3 clks, enable=1 -> ditherBits=0, frameStart=0. After release: frameStart=1 on the first edge.
//  2 ditherEn=0, divisor=8, width0=3, width1=0
//    -> ch0 pattern 11100000 repeats; ch1 stays 0; frameStart every 8 clks.
//  3 ditherEn=1, divisor=8, width0=4
//    -> ch0 offsets 0,5,2,1 in frames 1-4.
//    -> frame 2 is high at cnt 0,5,6,7 (wrap case); frame 3 is high at cnt 2-5.
//  4 Boundaries: width0=8 and divisor=8 -> constant 1; width0=31, divisor=0 -> frameStart stuck high, ch0=1;
//    divisor=63 -> frame length 32.
//  5 Change divisor 8->4 at cnt=3 -> current frame still runs 8 clks; following frames are 4 clks.
//  6 Drop enable at cnt=5 -> outputs 0 next edge.
//    -> Re-enable: ch0 offsets continue from the held LFSR.
//    -> Sync reset mid-frame: ch0 offsets restart at 0,5,...

Source files
------------

// File: rtl/prnd_pwm_dither_mc.sv
// prnd_pwm_dither_mc: multi-channel pseudorandom PWM dither generator.
// One on-chip frame counter is shared by all channels. Each channel owns a
// Galois LFSR that picks a per-frame start offset for its pulse window, and
// the window wraps modulo the frame length.
module prnd_pwm_dither_mc #(
  parameter int                       NUM_PRND_BITS = 5,
  parameter int                       NUM_CHANNELS  = 4,
  parameter logic [NUM_PRND_BITS-1:0] POLY          = 5'h14,
  parameter logic [NUM_PRND_BITS-1:0] SEED          = 5'h01
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic                                  i_ditherEn,
  input  logic [NUM_PRND_BITS:0]                i_divisor,
  input  logic [NUM_CHANNELS*NUM_PRND_BITS-1:0] i_width,
  output logic [NUM_CHANNELS-1:0]               o_ditherBits,
  output logic                                  o_frameStart
);

  localparam int W = NUM_PRND_BITS;
  localparam int N = NUM_CHANNELS;
  localparam logic [W:0] DIV_MAX = {1'b1, {W{1'b0}}};
  localparam logic [W:0] ONE_W1  = {{W{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t       r_state;
  logic [W:0]   r_cnt;
  logic [W:0]   r_divL;
  logic [W:0]   r_off  [N];
  logic [W-1:0] r_wL   [N];
  logic [W-1:0] r_lfsr [N];

  logic [W:0]   w_div_clamp;
  logic         w_load;
  logic [W:0]   w_nx_cnt;
  logic [W:0]   w_nx_divL;
  logic [2*W:0] w_prod   [N];
  logic [W:0]   w_nx_off [N];
  logic [W-1:0] w_nx_wL  [N];
  logic [N-1:0] w_nx_bits;

  // Seed for a channel: SEED+ch modulo 2^W, with the all-zero lock-up state avoided.
  function automatic logic [W-1:0] seed_of(input int ch);
    logic [W-1:0] s;
    s = SEED + W'(ch);
    if (s == {W{1'b0}}) begin
      s = {{(W-1){1'b0}}, 1'b1};
    end else begin
      s = s;
    end
    return s;
  endfunction

  // One right-shift Galois LFSR step.
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : {W{1'b0}});
  endfunction

  // Pulse window test: distance from the offset, wrapped into [0, divL), against the width.
  function automatic logic chan_hit(input logic [W:0] k, input logic [W:0] off,
                                    input logic [W:0] divl, input logic [W-1:0] wl);
    logic [W:0] d;
    if (k >= off) begin
      d = k - off;
    end else begin
      d = k + divl - off;
    end
    return (d < {1'b0, wl});
  endfunction

  // Next-state values: frame-load decision, clamped divisor, offsets and next-cycle outputs.
  always_comb begin
    if (i_divisor == {(W+1){1'b0}}) begin
      w_div_clamp = ONE_W1;
    end else if (i_divisor > DIV_MAX) begin
      w_div_clamp = DIV_MAX;
    end else begin
      w_div_clamp = i_divisor;
    end

    w_load    = i_enable && ((r_state == ST_IDLE) || (r_cnt == (r_divL - ONE_W1)));
    w_nx_cnt  = w_load ? {(W+1){1'b0}} : (r_cnt + ONE_W1);
    w_nx_divL = w_load ? w_div_clamp : r_divL;
    w_nx_bits = {N{1'b0}};

    for (int i = 0; i < N; i++) begin
      // Pre-advance LFSR value scaled by the new frame length keeps the offset below divL.
      w_prod[i] = {{(W+1){1'b0}}, r_lfsr[i]} * {{W{1'b0}}, w_div_clamp};
      if (w_load) begin
        w_nx_off[i] = i_ditherEn ? w_prod[i][2*W:W] : {(W+1){1'b0}};
        w_nx_wL[i]  = i_width[i*W +: W];
      end else begin
        w_nx_off[i] = r_off[i];
        w_nx_wL[i]  = r_wL[i];
      end
      w_nx_bits[i] = chan_hit(w_nx_cnt, w_nx_off[i], w_nx_divL, w_nx_wL[i]);
    end
  end

  // Frame FSM with registered outputs; outputs are computed for the cnt value being loaded.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {(W+1){1'b0}};
      r_divL       <= ONE_W1;
      o_ditherBits <= {N{1'b0}};
      o_frameStart <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_off[i]  <= {(W+1){1'b0}};
        r_wL[i]   <= {W{1'b0}};
        r_lfsr[i] <= seed_of(i);
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (i_enable) begin
            r_state      <= ST_RUN;
            r_cnt        <= w_nx_cnt;
            r_divL       <= w_nx_divL;
            o_ditherBits <= w_nx_bits;
            o_frameStart <= w_load;
            for (int i = 0; i < N; i++) begin
              r_off[i] <= w_nx_off[i];
              r_wL[i]  <= w_nx_wL[i];
              if (w_load) begin
                r_lfsr[i] <= lfsr_next(r_lfsr[i]);
              end else begin
                r_lfsr[i] <= r_lfsr[i];
              end
            end
          end else begin
            // Leaving RUN (or staying idle): clear outputs and counter, LFSRs hold.
            r_state      <= ST_IDLE;
            r_cnt        <= {(W+1){1'b0}};
            o_ditherBits <= {N{1'b0}};
            o_frameStart <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= {(W+1){1'b0}};
          o_ditherBits <= {N{1'b0}};
          o_frameStart <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prnd_pwm_dither_mc.sv
// Testbench for prnd_pwm_dither_mc (W=5, N=2, POLY=5'h14, SEED=1).
module tb_prnd_pwm_dither_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       de  = 1'b0;
  logic [5:0] div = 6'd8;
  logic [4:0] w0  = 5'd0;
  logic [4:0] w1  = 5'd0;
  logic [1:0] o_bits;
  logic       o_fs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prnd_pwm_dither_mc #(
    .NUM_PRND_BITS(5), .NUM_CHANNELS(2), .POLY(5'h14), .SEED(5'h01)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_ditherEn(de),
    .i_divisor(div), .i_width({w1, w0}),
    .o_ditherBits(o_bits), .o_frameStart(o_fs)
  );

  // Reference model: frame-level arithmetic, offset = floor(lfsr*divL/32),
  // membership by ((k - off) mod divL) < width.
  int         m_run, m_cnt, m_div;
  int         m_off [2];
  int         m_w   [2];
  int         m_lfsr[2];
  logic [1:0] exp_bits = 2'b00;
  logic       exp_fs   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_cnt = 0; m_div = 1;
      m_lfsr[0] = 1; m_lfsr[1] = 2;
      exp_bits = 2'b00; exp_fs = 1'b0;
    end else if (!en) begin
      m_run = 0; m_cnt = 0;
      exp_bits = 2'b00; exp_fs = 1'b0;
    end else begin
      if (!m_run || m_cnt == m_div - 1) begin
        m_div = (div == 0) ? 1 : ((div > 32) ? 32 : int'(div));
        m_w[0] = int'(w0);
        m_w[1] = int'(w1);
        for (int c = 0; c < 2; c++) begin
          m_off[c]  = de ? (m_lfsr[c] * m_div) / 32 : 0;
          m_lfsr[c] = (m_lfsr[c] >> 1) ^ (((m_lfsr[c] % 2) == 1) ? 20 : 0);
        end
        m_cnt = 0; m_run = 1; exp_fs = 1'b1;
      end else begin
        m_cnt = m_cnt + 1; exp_fs = 1'b0;
      end
      for (int c = 0; c < 2; c++)
        exp_bits[c] = (((m_cnt - m_off[c] + m_div) % m_div) < m_w[c]);
    end
  end

  // Drop enable for one clock, load new settings, then re-enable.
  task automatic restart(input logic d_en, input logic [5:0] dv, input logic [4:0] a, input logic [4:0] b);
    en = 1'b0;
    @(posedge clk); #1;
    de = d_en; div = dv; w0 = a; w1 = b; en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; de = 1'b0; div = 6'd8; w0 = 5'd3; w1 = 5'd0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits !== 2'b00 || o_fs !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: bits=%b fs=%b, required bits=00 fs=0", o_bits, o_fs);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (o_fs !== 1'b1 || o_bits !== 2'b01) begin
      n_err++;
      $display("FAIL reset_release: bits=%b fs=%b, required bits=01 fs=1", o_bits, o_fs);
    end
  endtask

  task automatic test_plain();
    logic [7:0] pat;
    pat = 8'b0000_0111;
    restart(1'b0, 6'd8, 5'd3, 5'd0);
    for (int j = 0; j < 24; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits !== {1'b0, pat[j % 8]} || o_fs !== (j % 8 == 0)) begin
        n_err++;
        $display("FAIL plain_pwm j=%0d: bits=%b fs=%b, required bits=%b fs=%b",
                 j, o_bits, o_fs, {1'b0, pat[j % 8]}, (j % 8 == 0));
      end
    end
  endtask

  task automatic test_dither();
    logic [7:0] pats [4];
    pats[0] = 8'b0000_1111; pats[1] = 8'b1110_0001;
    pats[2] = 8'b0011_1100; pats[3] = 8'b0001_1110;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; de = 1'b1; div = 6'd8; w0 = 5'd4; w1 = 5'($urandom_range(0, 9)); en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits[0] !== pats[j / 8][j % 8] || o_fs !== (j % 8 == 0)) begin
        n_err++;
        $display("FAIL dither_ch0 frame=%0d cnt=%0d: bit=%b fs=%b, required bit=%b fs=%b",
                 j / 8 + 1, j % 8, o_bits[0], o_fs, pats[j / 8][j % 8], (j % 8 == 0));
      end
      n_vec++;
      if (o_bits[1] !== exp_bits[1]) begin
        n_err++;
        $display("FAIL dither_ch1 j=%0d: bit=%b, required %b", j, o_bits[1], exp_bits[1]);
      end
    end
  endtask

  task automatic test_boundaries();
    restart(logic'($urandom_range(0, 1)), 6'd8, 5'd8, 5'd0);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits !== 2'b01) begin
        n_err++;
        $display("FAIL width_eq_div j=%0d: bits=%b, required 01", j, o_bits);
      end
    end
    restart(1'b1, 6'd0, 5'd31, 5'($urandom_range(0, 1)));
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_fs !== 1'b1 || o_bits !== {(w1 != 5'd0), 1'b1}) begin
        n_err++;
        $display("FAIL div_zero j=%0d: bits=%b fs=%b, required bits=%b fs=1",
                 j, o_bits, o_fs, {(w1 != 5'd0), 1'b1});
      end
    end
    restart(1'b1, 6'd63, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int j = 0; j < 64; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_fs !== (j % 32 == 0) || o_bits !== exp_bits) begin
        n_err++;
        $display("FAIL div_clamp j=%0d: bits=%b fs=%b, required bits=%b fs=%b",
                 j, o_bits, o_fs, exp_bits, (j % 32 == 0));
      end
    end
  endtask

  task automatic test_div_change();
    logic fs_req;
    restart(1'b0, 6'd8, 5'd2, 5'd1);
    for (int j = 0; j < 21; j++) begin
      @(posedge clk); #1;
      if (j == 3) div = 6'd4;
      fs_req = (j == 0) || (j >= 8 && ((j - 8) % 4 == 0));
      n_vec++;
      if (o_fs !== fs_req || o_bits !== exp_bits) begin
        n_err++;
        $display("FAIL div_change j=%0d: fs=%b bits=%b, required fs=%b bits=%b",
                 j, o_fs, o_bits, fs_req, exp_bits);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] pats [3];
    pats[0] = 8'b0000_1111; pats[1] = 8'b1110_0001; pats[2] = 8'b0011_1100;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; de = 1'b1; div = 6'd8; w0 = 5'd4; w1 = 5'd0; en = 1'b1;
    repeat (6) @(posedge clk);
    #1; en = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (o_bits !== 2'b00 || o_fs !== 1'b0) begin
      n_err++;
      $display("FAIL enable_drop: bits=%b fs=%b, required bits=00 fs=0", o_bits, o_fs);
    end
    en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits[0] !== pats[1 + j / 8][j % 8] || o_fs !== (j % 8 == 0)) begin
        n_err++;
        $display("FAIL reenable j=%0d: bit=%b fs=%b, required bit=%b fs=%b",
                 j, o_bits[0], o_fs, pats[1 + j / 8][j % 8], (j % 8 == 0));
      end
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (o_bits !== 2'b00 || o_fs !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset: bits=%b fs=%b, required bits=00 fs=0", o_bits, o_fs);
    end
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      n_vec++;
      if (o_bits[0] !== pats[j / 8][j % 8] || o_fs !== (j % 8 == 0)) begin
        n_err++;
        $display("FAIL post_reset j=%0d: bit=%b fs=%b, required bit=%b fs=%b",
                 j, o_bits[0], o_fs, pats[j / 8][j % 8], (j % 8 == 0));
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 2000; j++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 19) != 0);
      de  = logic'($urandom_range(0, 1));
      div = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 12));
      w0  = 5'($urandom_range(0, 31));
      w1  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      n_vec++;
      if (o_bits !== exp_bits || o_fs !== exp_fs) begin
        n_err++;
        $display("FAIL random j=%0d: bits=%b fs=%b, required bits=%b fs=%b",
                 j, o_bits, o_fs, exp_bits, exp_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_dither();
    test_boundaries();
    test_div_change();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
